// File: rtl/crossbar_pkg.sv
// Shared crossbar types and constants: slave FSM state encoding, command
// codes, wait-counter width and default bus widths.
package crossbar_pkg;

    localparam int unsigned DW_DEFAULT = 8;
    localparam int unsigned AW_DEFAULT = 4;

    // Wait counter width; LATENCY is limited to 0..15 so it never wraps.
    localparam int unsigned CNT_W = 4;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/slave_regfile.sv
// DEPTH x DW register file behind a slave endpoint.
// Ports:
//   clk, reset   clock, asynchronous active-high reset (all words -> RESET_VAL)
//   we           synchronous write enable
//   waddr/wdata  write address/data; writes to addr >= DEPTH are dropped
//   raddr        combinational read address
//   rdata_c      combinational read data; 0 for addr >= DEPTH
module slave_regfile #(
    parameter int unsigned DW        = 8,
    parameter int unsigned AW        = 4,
    parameter int unsigned DEPTH     = 12,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata_c
);

    logic [DW-1:0] mem [DEPTH];

    // Address decode by comparison so unmapped addresses match no word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= DW'(RESET_VAL);
            end
        end else if (we) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (waddr == AW'(i)) begin
                    mem[i] <= wdata;
                end
            end
        end
    end

    // Unmapped reads fall through to zero.
    always_comb begin
        rdata_c = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (raddr == AW'(i)) begin
                rdata_c = mem[i];
            end
        end
    end

endmodule

// File: rtl/slave_mem.sv
// Crossbar slave endpoint: accepts an arbitrated request, waits LATENCY
// cycles, then commits the access to a small register file and strobes ack.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   req         request, held high by the arbiter until ack
//   cmd         1 = write, 0 = read (sampled with req)
//   addr        word address (sampled with req)
//   wdata       write data (sampled with req)
//   ack         one-cycle completion strobe
//   rdata       read data, valid in the ack cycle and held afterwards
//   busy        high whenever the FSM is not IDLE
module slave_mem
    import crossbar_pkg::*;
#(
    parameter int unsigned DW        = DW_DEFAULT,
    parameter int unsigned AW        = AW_DEFAULT,
    parameter int unsigned DEPTH     = 12,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          cmd,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ack,
    output logic [DW-1:0] rdata,
    output logic          busy
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic             h_cmd;
    logic [AW-1:0]    h_addr;
    logic [DW-1:0]    h_wdata;

    logic             commit_c;
    logic             op_cmd_c;
    logic [AW-1:0]    op_addr_c;
    logic [DW-1:0]    op_wdata_c;
    logic [DW-1:0]    rf_rdata_c;

    // State register and wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; dropping req during WAIT aborts the transaction.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    if (LATENCY == 0) begin
                        state_nxt = ACK;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_W'(LATENCY);
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt > CNT_W'(1)) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    state_nxt = ACK;
                    cnt_nxt   = '0;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        ack  = 1'b0;
        busy = 1'b0;
        if (state == ACK) begin
            ack = 1'b1;
        end
        if (state != IDLE) begin
            busy = 1'b1;
        end
    end

    // Holding registers capture the operands on acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cmd   <= CMD_READ;
            h_addr  <= '0;
            h_wdata <= '0;
        end else if (state == IDLE && req) begin
            h_cmd   <= cmd;
            h_addr  <= addr;
            h_wdata <= wdata;
        end
    end

    // With zero latency the commit happens on the accepting edge, so the
    // operands come straight from the inputs rather than the holding regs.
    always_comb begin
        commit_c   = (state != ACK) && (state_nxt == ACK);
        op_cmd_c   = h_cmd;
        op_addr_c  = h_addr;
        op_wdata_c = h_wdata;
        if (state == IDLE) begin
            op_cmd_c   = cmd;
            op_addr_c  = addr;
            op_wdata_c = wdata;
        end
    end

    slave_regfile #(
        .DW        (DW),
        .AW        (AW),
        .DEPTH     (DEPTH),
        .RESET_VAL (RESET_VAL)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (commit_c && (op_cmd_c == CMD_WRITE)),
        .waddr   (op_addr_c),
        .wdata   (op_wdata_c),
        .raddr   (op_addr_c),
        .rdata_c (rf_rdata_c)
    );

    // Read data loads on the edge entering ACK; writes leave it untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= DW'(RESET_VAL);
        end else if (commit_c && (op_cmd_c == CMD_READ)) begin
            rdata <= rf_rdata_c;
        end
    end

endmodule

// File: tb/tb_slave_mem.sv
// Bench for slave_mem: three instances (LATENCY 2, 0, 3), a transaction-level
// memory model feeding an expected-ack queue, and a negedge monitor.
module tb_slave_mem;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 12;
    localparam int          NI    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_v   [NI];
    logic          cmd_v   [NI];
    logic [AW-1:0] addr_v  [NI];
    logic [DW-1:0] wdata_v [NI];
    logic          ack_v   [NI];
    logic          busy_v  [NI];
    logic [DW-1:0] rdata_v [NI];

    always #5 clk = ~clk;

    slave_mem #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .LATENCY(2), .RESET_VAL(0)) u0 (
        .clk(clk), .reset(reset), .req(req_v[0]), .cmd(cmd_v[0]), .addr(addr_v[0]),
        .wdata(wdata_v[0]), .ack(ack_v[0]), .rdata(rdata_v[0]), .busy(busy_v[0]));
    slave_mem #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .LATENCY(0), .RESET_VAL(0)) u1 (
        .clk(clk), .reset(reset), .req(req_v[1]), .cmd(cmd_v[1]), .addr(addr_v[1]),
        .wdata(wdata_v[1]), .ack(ack_v[1]), .rdata(rdata_v[1]), .busy(busy_v[1]));
    slave_mem #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .LATENCY(3), .RESET_VAL(0)) u2 (
        .clk(clk), .reset(reset), .req(req_v[2]), .cmd(cmd_v[2]), .addr(addr_v[2]),
        .wdata(wdata_v[2]), .ack(ack_v[2]), .rdata(rdata_v[2]), .busy(busy_v[2]));

    typedef struct {
        int            inst;
        int            cyc;
        logic [DW-1:0] rd;
    } exp_t;

    exp_t sbq[$];
    int   lat      [NI];
    int   mem_m    [NI][16];
    int   last_rd  [NI];
    int   last_ack [NI];
    int   pend_acc;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    // Cycle index: after edge k, cyc == k.
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            for (int a = 0; a < 16; a++) mem_m[i][a] = 0;
            last_rd[i] = 0;
        end
    endtask

    // Drive a request at a negedge and predict its ack cycle and rdata.
    // A request is accepted on the next edge, or two edges after the previous
    // ack if that is later; ack follows acceptance by LATENCY edges.
    task automatic issue(input int i, input bit c, input int a, input int d);
        exp_t e;
        int   acc;
        req_v[i]   = 1'b1;
        cmd_v[i]   = c;
        addr_v[i]  = AW'(a);
        wdata_v[i] = DW'(d);
        acc = (cyc + 1 > last_ack[i] + 2) ? cyc + 1 : last_ack[i] + 2;
        e.inst = i;
        e.cyc  = acc + lat[i];
        if (c) begin
            e.rd = DW'(last_rd[i]);
            if (a < int'(DEPTH)) mem_m[i][a] = d;
        end else begin
            e.rd = (a < int'(DEPTH)) ? DW'(mem_m[i][a]) : '0;
            last_rd[i] = int'(e.rd);
        end
        last_ack[i] = e.cyc;
        pend_acc    = acc;
        sbq.push_back(e);
    endtask

    // Wait for ack; optionally scramble operands once the request is latched.
    task automatic wait_ack(input int i, input bit scramble);
        int n;
        n = 0;
        @(negedge clk);
        while (!ack_v[i] && n < 40) begin
            if (scramble && cyc >= pend_acc) begin
                addr_v[i]  = AW'($urandom);
                wdata_v[i] = DW'($urandom);
                cmd_v[i]   = 1'($urandom);
            end
            @(negedge clk);
            n++;
        end
        if (!ack_v[i]) chk("ack_timeout", 0, 1);
    endtask

    // Monitor: every ack is matched against the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            for (int i = 0; i < NI; i++) begin
                if (ack_v[i]) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_ack", i, -1);
                    end else begin
                        e = sbq.pop_front();
                        chk("ack_instance", i, e.inst);
                        chk("ack_cycle", cyc, e.cyc);
                        chk("ack_rdata", int'(rdata_v[i]), int'(e.rd));
                    end
                end
            end
        end
    end

    initial begin
        lat[0] = 2; lat[1] = 0; lat[2] = 3;
        for (int i = 0; i < NI; i++) begin
            req_v[i] = 1'b0; cmd_v[i] = 1'b0; addr_v[i] = '0; wdata_v[i] = '0;
            last_ack[i] = -10;
        end
        model_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NI; i++) begin
            chk("reset_ack", int'(ack_v[i]), 0);
            chk("reset_busy", int'(busy_v[i]), 0);
            chk("reset_rdata", int'(rdata_v[i]), 0);
        end
        @(negedge clk);

        // Read of addr 3 with two wait states: busy for three cycles, ack on the third.
        issue(0, 1'b0, 3, 0);
        chk("t1_busy_before", int'(busy_v[0]), 0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("t1_busy", int'(busy_v[0]), 1);
            if (k < 3) chk("t1_no_early_ack", int'(ack_v[0]), 0);
        end
        req_v[0] = 1'b0;
        @(negedge clk);
        chk("t1_busy_after", int'(busy_v[0]), 0);

        // Write then back-to-back read of the same word.
        issue(0, 1'b1, 5, 'hA5);
        wait_ack(0, 1'b0);
        issue(0, 1'b0, 5, 0);
        wait_ack(0, 1'b0);
        req_v[0] = 1'b0;
        @(negedge clk);

        // Abort a write after one wait cycle.
        req_v[0] = 1'b1; cmd_v[0] = 1'b1; addr_v[0] = 4'd2; wdata_v[0] = 8'h3C;
        @(negedge clk);
        chk("abort_busy_wait", int'(busy_v[0]), 1);
        req_v[0] = 1'b0;
        @(negedge clk);
        chk("abort_busy_idle", int'(busy_v[0]), 0);
        chk("abort_no_ack", int'(ack_v[0]), 0);
        issue(0, 1'b0, 2, 0);
        wait_ack(0, 1'b0);
        req_v[0] = 1'b0;

        // Unmapped write and read, then read back all mapped words.
        issue(0, 1'b1, 13, 'hFF);
        wait_ack(0, 1'b0);
        issue(0, 1'b0, 13, 0);
        wait_ack(0, 1'b0);
        for (int a = 0; a < int'(DEPTH); a++) begin
            issue(0, 1'b0, a, 0);
            wait_ack(0, 1'b0);
        end
        req_v[0] = 1'b0;

        // Zero-latency instance.
        issue(1, 1'b0, 4, 0);
        wait_ack(1, 1'b0);
        issue(1, 1'b1, 4, 'h5A);
        wait_ack(1, 1'b0);
        issue(1, 1'b0, 4, 0);
        wait_ack(1, 1'b0);
        req_v[1] = 1'b0;

        // Operands change during WAIT on the three-cycle instance.
        issue(2, 1'b1, 7, 'h42);
        wait_ack(2, 1'b1);
        req_v[2] = 1'b0;
        @(negedge clk);
        issue(2, 1'b0, 7, 0);
        wait_ack(2, 1'b1);
        req_v[2] = 1'b0;
        @(negedge clk);

        // Reset in the middle of a write wait.
        issue(0, 1'b1, 1, 'h11);
        wait_ack(0, 1'b0);
        req_v[0] = 1'b0;
        @(negedge clk);
        req_v[0] = 1'b1; cmd_v[0] = 1'b1; addr_v[0] = 4'd1; wdata_v[0] = 8'h77;
        @(negedge clk);
        chk("rst_mid_busy_before", int'(busy_v[0]), 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_busy", int'(busy_v[0]), 0);
        chk("rst_mid_ack", int'(ack_v[0]), 0);
        chk("rst_mid_rdata", int'(rdata_v[0]), 0);
        @(negedge clk);
        reset = 1'b0;
        req_v[0] = 1'b0;
        model_reset();
        @(negedge clk);
        issue(0, 1'b0, 1, 0);
        wait_ack(0, 1'b0);
        req_v[0] = 1'b0;
        @(negedge clk);

        // Randomized traffic per instance, with random back-to-back requests.
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 50; k++) begin
                issue(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 255)));
                wait_ack(i, 1'b1);
                if ($urandom_range(0, 2) != 0) begin
                    req_v[i] = 1'b0;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            req_v[i] = 1'b0;
            repeat (2) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
